rr_resp_router: RTL and testbench
=================================

// Module: rr_resp_router
// PURPOSE
//  Return path of the round-robin arbitrated shared resource (e.g. RF read rows). Records each
//  nonzero grant vector issued by the arbiter in an in-order FIFO; when the resource returns a
//  response beat carrying NumActOut data lanes, it routes lane k to the k-th granted requester.
//  It sits between the shared resource output and the per-requester consumers.
// PARAMETERS
//  WIDTH      8   number of requesters (grant vector width)
//  NumActOut  3   max grants per arbitration cycle = data lanes per response beat
//  DATA_W     32  bits per data lane
//  DEPTH      4   outstanding grant vectors (power of 2, >=2)
// PORTS
//  clk_i         in   1                 clock
//  rst_i         in   1                 synchronous reset, active-high
//  grant_i       in   WIDTH             arbiter grant vector; pushed when nonzero
//  grant_ready_o out  1                 FIFO not full
//  resp_valid_i  in   1                 response beat valid
//  resp_ready_o  out  1                 response beat accepted
//  resp_data_i   in   NumActOut*DATA_W  lane k at [k*DATA_W +: DATA_W]
//  rvalid_o      out  WIDTH             per-requester data valid (registered)
//  rdata_o       out  WIDTH*DATA_W      requester j data at [j*DATA_W +: DATA_W]
//  rready_i      in   WIDTH             per-requester accept
//  outstanding_o out  $clog2(DEPTH)+1   FIFO occupancy
//  overflow_o    out  1                 sticky: grant dropped because FIFO full
//  popcnt_err_o  out  1                 sticky: grant vector with more than NumActOut bits set
// BEHAVIOUR
//  - Reset: FIFO empty, rvalid_o=0, rdata_o=0, outstanding_o=0, overflow_o=0, popcnt_err_o=0.
//  - grant_ready_o = !full (no dependence on same-cycle pop; no comb path from resp side).
//  - Push: |grant_i && !full -> grant_i written at tail, occupancy +1 next cycle.
//    |grant_i && full -> vector dropped, overflow_o<=1 (stays set until reset).
//    grant_i==0 -> no action.
//  - popcnt_err_o<=1 when a pushed vector has popcount>NumActOut; vector is still stored,
//    set bits beyond the NumActOut-th (ascending index) receive no data, no rvalid.
//  - Output stage busy = |(rvalid_o & ~rready_i).
//    resp_ready_o = !empty && !busy (combinational from FIFO state, rvalid_o, rready_i).
//  - Pop: resp_valid_i && resp_ready_o. Head vector G; lane k maps to the k-th set bit of G
//    counted from bit 0 upward. Next cycle: rvalid_o[j]=1 and rdata_o[j]=lane for every mapped
//    j; other rvalid_o bits 0, their rdata_o unchanged. Latency accept->rvalid_o = 1 cycle.
//    Lanes beyond popcount(G) ignored.
//  - rvalid_o[j] cleared the cycle after rvalid_o[j]&&rready_i[j] unless re-set by a pop in
//    the same cycle (pop allowed only when all pending bits consume this cycle; pop wins).
//  - Simultaneous push and pop: both occur; occupancy unchanged. Push when full with same-cycle
//    pop: dropped (grant_ready_o was low), overflow_o set.
//  - resp_valid_i while empty: not accepted (resp_ready_o=0), no state change.
//  - Pointers wrap modulo DEPTH; full/empty from occupancy counter 0..DEPTH.
//  - Reset mid-operation: FIFO contents discarded, pending rvalid_o dropped, sticky flags cleared.
//  - Data path assumes resource returns beats in grant order (in-order resource).
// STRUCTURE
//  - Package rr_pkg: lane index typedef logic [$clog2(NumActOut)-1:0]; function
//    lane_map(grant) returning per-requester {hit, lane}; function popcount(grant).
//  - Sub-module rr_grant_fifo (sync FIFO, WIDTH x DEPTH, push/pop/full/empty/count).
//  - Top: lane mapping + output register stage + sticky error flags.
// TESTING (WIDTH=8, NumActOut=3, DATA_W=32, DEPTH=4)
//  1 grant_i=8'b0010_0101, then resp beat lanes {C,B,A}={3,2,1}, rready_i=FF -> next cycle
//    rvalid_o=8'b0010_0101, rdata[0]=1, rdata[2]=2, rdata[5]=3; cleared one cycle later.
//  2 Push 4 nonzero grants, no resp -> grant_ready_o=0, outstanding_o=4; 5th grant -> dropped,
//    overflow_o=1; pop 4 beats -> outputs in push order, outstanding_o=0, overflow_o stays 1.
//  3 grant_i=8'b1111_0000 -> popcnt_err_o=1; beat {30,20,10} -> rvalid_o=8'b0111_0000, bit7 0.
//  4 rready_i[0]=0 holding rvalid_o[0]; next beat valid -> resp_ready_o=0 until rready_i[0]=1,
//    then accepted same cycle, new rvalid_o set next cycle (back-to-back, no bubble).
//  5 Simultaneous push and pop at occupancy 2 -> occupancy stays 2; resp_valid_i when empty
//    -> resp_ready_o=0; wrap test: 10 push/pop pairs preserve order.
//  6 rst_i asserted with 3 outstanding and rvalid_o pending -> next cycle all outputs at reset
//    values; subsequent grant/resp pair routed correctly.

Source files
------------

// File: rtl/rr_pkg.sv
// Shared types and helpers for the round-robin response router: lane indices and
// the grant-bit to data-lane mapping used on the return path.
package rr_pkg;

  localparam int MAX_WIDTH   = 64;
  localparam int NUM_ACT_OUT = 3;
  localparam int LANE_W      = (NUM_ACT_OUT > 1) ? $clog2(NUM_ACT_OUT) : 1;

  typedef logic [LANE_W-1:0] lane_idx_t;

  typedef struct packed {
    logic      hit;
    lane_idx_t lane;
  } lane_hit_t;

  function automatic int popcount(input logic [MAX_WIDTH-1:0] grant);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (grant[i]) cnt++;
    end
    return cnt;
  endfunction

  // Requester idx takes the lane equal to the number of granted requesters below it,
  // provided that lane exists.
  function automatic lane_hit_t lane_map(input logic [MAX_WIDTH-1:0] grant,
                                         input int idx, input int num_act);
    lane_hit_t res;
    int        below;
    below = 0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < idx && grant[i]) below++;
    end
    res.hit  = grant[idx] && (below < num_act);
    res.lane = lane_idx_t'(below);
    return res;
  endfunction

endpackage

// File: rtl/rr_grant_fifo.sv
// In-order FIFO of issued grant vectors; occupancy counter drives full/empty.
module rr_grant_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rr_resp_router.sv
// Return path of the round-robin shared resource: remembers grant order and steers
// each response lane to the requester that was granted it.
module rr_resp_router
  import rr_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NumActOut = NUM_ACT_OUT,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [WIDTH-1:0]            grant_i,
  output logic                        grant_ready_o,
  input  logic                        resp_valid_i,
  output logic                        resp_ready_o,
  input  logic [NumActOut*DATA_W-1:0] resp_data_i,
  output logic [WIDTH-1:0]            rvalid_o,
  output logic [WIDTH*DATA_W-1:0]     rdata_o,
  input  logic [WIDTH-1:0]            rready_i,
  output logic [$clog2(DEPTH):0]      outstanding_o,
  output logic                        overflow_o,
  output logic                        popcnt_err_o
);

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [WIDTH-1:0]     head_grant;
  logic                 grant_any;
  logic                 push;
  logic                 pop;
  logic                 busy;
  logic [MAX_WIDTH-1:0] head_ext;
  logic [MAX_WIDTH-1:0] grant_ext;
  lane_hit_t            map [WIDTH];
  logic [DATA_W-1:0]    lane_data [WIDTH];

  assign grant_any     = |grant_i;
  assign push          = grant_any && !fifo_full;
  assign grant_ready_o = !fifo_full;
  assign busy          = |(rvalid_o & ~rready_i);
  assign resp_ready_o  = !fifo_empty && !busy;
  assign pop           = resp_valid_i && resp_ready_o;
  assign head_ext      = MAX_WIDTH'(head_grant);
  assign grant_ext     = MAX_WIDTH'(grant_i);

  rr_grant_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .wdata (grant_i),
    .pop   (pop),
    .rdata (head_grant),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding_o)
  );

  always_comb begin
    for (int j = 0; j < WIDTH; j++) begin
      map[j]       = lane_map(head_ext, j, NumActOut);
      lane_data[j] = '0;
      for (int k = 0; k < NumActOut; k++) begin
        if (int'(map[j].lane) == k) lane_data[j] = resp_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // A pop only happens once every pending bit is consumed, so it may overwrite all of rvalid_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_o     <= '0;
      rdata_o      <= '0;
      overflow_o   <= 1'b0;
      popcnt_err_o <= 1'b0;
    end else begin
      for (int j = 0; j < WIDTH; j++) begin
        if (pop) begin
          rvalid_o[j] <= map[j].hit;
        end else if (rready_i[j]) begin
          rvalid_o[j] <= 1'b0;
        end
        if (pop && map[j].hit) rdata_o[j*DATA_W +: DATA_W] <= lane_data[j];
      end
      if (grant_any && fifo_full) overflow_o <= 1'b1;
      if (push && popcount(grant_ext) > NumActOut) popcnt_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_resp_router.sv
// Scoreboard bench for rr_resp_router: expected routed outputs are queued on beat
// acceptance and compared when the registered outputs appear.
module tb_rr_resp_router;

  localparam int W  = 8;
  localparam int NA = 3;
  localparam int DW = 32;
  localparam int D  = 4;

  typedef struct packed {
    logic [W-1:0]    mask;
    logic [W*DW-1:0] data;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [W-1:0]      grant;
  logic              grant_ready;
  logic              resp_valid;
  logic              resp_ready;
  logic [NA*DW-1:0]  resp_data;
  logic [W-1:0]      rvalid;
  logic [W*DW-1:0]   rdata;
  logic [W-1:0]      rready;
  logic [2:0]        outstanding;
  logic              overflow;
  logic              popcnt_err;

  logic [W-1:0]      gq [$];
  exp_t              sb [$];
  logic [W*DW-1:0]   exp_rdata;
  logic              exp_ovf;
  logic              exp_perr;
  int                n_cmp;
  int                n_err;

  rr_resp_router #(.WIDTH(W), .NumActOut(NA), .DATA_W(DW), .DEPTH(D)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .grant_i       (grant),
    .grant_ready_o (grant_ready),
    .resp_valid_i  (resp_valid),
    .resp_ready_o  (resp_ready),
    .resp_data_i   (resp_data),
    .rvalid_o      (rvalid),
    .rdata_o       (rdata),
    .rready_i      (rready),
    .outstanding_o (outstanding),
    .overflow_o    (overflow),
    .popcnt_err_o  (popcnt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    gq.delete();
    sb.delete();
    exp_rdata = '0;
    exp_ovf   = 1'b0;
    exp_perr  = 1'b0;
  endtask

  task automatic model_push(input logic [W-1:0] g);
    int c;
    c = 0;
    for (int i = 0; i < W; i++) if (g[i]) c++;
    if (g == '0) return;
    if (gq.size() < D) begin
      gq.push_back(g);
      if (c > NA) exp_perr = 1'b1;
    end else begin
      exp_ovf = 1'b1;
    end
  endtask

  task automatic model_accept(input logic [NA*DW-1:0] lanes);
    logic [W-1:0] g;
    logic [W-1:0] m;
    int           k;
    if (gq.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL model_accept: observed beat with no grant outstanding, required outstanding grant");
      return;
    end
    g = gq.pop_front();
    m = '0;
    k = 0;
    for (int j = 0; j < W; j++) begin
      if (g[j]) begin
        if (k < NA) begin
          m[j] = 1'b1;
          exp_rdata[j*DW +: DW] = lanes[k*DW +: DW];
        end
        k++;
      end
    end
    sb.push_back('{mask: m, data: exp_rdata});
  endtask

  task automatic push_grant(input logic [W-1:0] g);
    grant = g;
    model_push(g);
    @(negedge clk);
    grant = '0;
  endtask

  task automatic send_beat(input logic [NA*DW-1:0] lanes);
    resp_valid = 1'b1;
    resp_data  = lanes;
    model_accept(lanes);
    @(negedge clk);
    resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    e = '{mask: '0, data: '0};
    n_cmp++; if (rvalid !== e.mask) begin n_err++; $display("[TB] FAIL reset_rvalid: observed %h, required %h", rvalid, e.mask); end
    n_cmp++; if (rdata !== e.data) begin n_err++; $display("[TB] FAIL reset_rdata: observed %h, required 0", rdata); end
    n_cmp++; if ({outstanding, overflow, popcnt_err, grant_ready, resp_ready} !== 7'b000_0010) begin
      n_err++; $display("[TB] FAIL reset_status: observed occ=%0d ovf=%b perr=%b gr=%b rr=%b, required 0/0/0/1/0",
                        outstanding, overflow, popcnt_err, grant_ready, resp_ready); end
  endtask

  task automatic test_basic_route();
    exp_t e;
    push_grant(8'b0010_0101);
    n_cmp++; if (outstanding !== 3'd1) begin n_err++; $display("[TB] FAIL basic_occ: observed %0d, required 1", outstanding); end
    send_beat({32'd3, 32'd2, 32'd1});
    e = sb.pop_front();
    n_cmp++; if (rvalid !== e.mask) begin n_err++; $display("[TB] FAIL basic_rvalid: observed %b, required %b", rvalid, e.mask); end
    n_cmp++; if (rdata !== e.data) begin n_err++; $display("[TB] FAIL basic_rdata: observed %h, required %h", rdata, e.data); end
    @(negedge clk);
    n_cmp++; if (rvalid !== 8'h00) begin n_err++; $display("[TB] FAIL basic_clear: observed %b, required 0", rvalid); end
  endtask

  task automatic test_overflow();
    exp_t        e;
    logic [W-1:0] gs [4];
    gs = '{8'h03, 8'h18, 8'h81, 8'h44};
    for (int i = 0; i < 4; i++) push_grant(gs[i]);
    n_cmp++; if (grant_ready !== 1'b0 || outstanding !== 3'd4) begin
      n_err++; $display("[TB] FAIL full_status: observed gr=%b occ=%0d, required gr=0 occ=4", grant_ready, outstanding); end
    push_grant(8'h10);
    n_cmp++; if (overflow !== exp_ovf || outstanding !== 3'd4) begin
      n_err++; $display("[TB] FAIL overflow: observed ovf=%b occ=%0d, required ovf=%b occ=4", overflow, outstanding, exp_ovf); end
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (resp_ready !== 1'b1) begin n_err++; $display("[TB] FAIL drain_ready%0d: observed %b, required 1", i, resp_ready); end
      send_beat({$urandom, $urandom, $urandom});
      e = sb.pop_front();
      n_cmp++; if (rvalid !== e.mask || rdata !== e.data) begin
        n_err++; $display("[TB] FAIL drain_out%0d: observed %b/%h, required %b/%h", i, rvalid, rdata, e.mask, e.data); end
    end
    n_cmp++; if (outstanding !== 3'd0 || overflow !== 1'b1) begin
      n_err++; $display("[TB] FAIL drained_status: observed occ=%0d ovf=%b, required occ=0 ovf=1", outstanding, overflow); end
  endtask

  task automatic test_popcount();
    exp_t e;
    push_grant(8'b1111_0000);
    n_cmp++; if (popcnt_err !== exp_perr || exp_perr !== 1'b1) begin
      n_err++; $display("[TB] FAIL popcnt_err: observed %b, required 1", popcnt_err); end
    send_beat({32'd30, 32'd20, 32'd10});
    e = sb.pop_front();
    n_cmp++; if (rvalid !== e.mask || rdata !== e.data) begin
      n_err++; $display("[TB] FAIL popcnt_route: observed %b/%h, required %b/%h", rvalid, rdata, e.mask, e.data); end
  endtask

  task automatic test_back_to_back();
    exp_t             e;
    logic [NA*DW-1:0] lanes;
    push_grant(8'h01);
    push_grant(8'h03);
    rready = 8'hFE;
    send_beat({32'd0, 32'd0, 32'hA5A5_0001});
    e = sb.pop_front();
    n_cmp++; if (rvalid !== e.mask || rdata !== e.data) begin
      n_err++; $display("[TB] FAIL hold_first: observed %b/%h, required %b/%h", rvalid, rdata, e.mask, e.data); end
    lanes      = {32'd0, 32'h0000_BEEF, 32'h0000_CAFE};
    resp_valid = 1'b1;
    resp_data  = lanes;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (resp_ready !== 1'b0 || rvalid !== 8'h01) begin
        n_err++; $display("[TB] FAIL stall%0d: observed rr=%b rvalid=%b, required rr=0 rvalid=01", i, resp_ready, rvalid); end
      @(negedge clk);
    end
    rready = 8'hFF;
    #1;
    n_cmp++; if (resp_ready !== 1'b1) begin n_err++; $display("[TB] FAIL release_ready: observed %b, required 1", resp_ready); end
    model_accept(lanes);
    @(negedge clk);
    resp_valid = 1'b0;
    e = sb.pop_front();
    n_cmp++; if (rvalid !== e.mask || rdata !== e.data) begin
      n_err++; $display("[TB] FAIL b2b_out: observed %b/%h, required %b/%h", rvalid, rdata, e.mask, e.data); end
  endtask

  task automatic test_simul_and_wrap();
    exp_t             e;
    logic [NA*DW-1:0] lanes;
    logic [W-1:0]     g;
    push_grant(8'h06);
    push_grant(8'h90);
    lanes      = {32'h33, 32'h22, 32'h11};
    grant      = 8'h0C;
    resp_valid = 1'b1;
    resp_data  = lanes;
    model_accept(lanes);
    model_push(8'h0C);
    @(negedge clk);
    grant      = '0;
    resp_valid = 1'b0;
    e = sb.pop_front();
    n_cmp++; if (outstanding !== 3'd2) begin n_err++; $display("[TB] FAIL simul_occ: observed %0d, required 2", outstanding); end
    n_cmp++; if (rvalid !== e.mask || rdata !== e.data) begin
      n_err++; $display("[TB] FAIL simul_out: observed %b/%h, required %b/%h", rvalid, rdata, e.mask, e.data); end
    for (int i = 0; i < 2; i++) begin
      send_beat({$urandom, $urandom, $urandom});
      e = sb.pop_front();
      n_cmp++; if (rvalid !== e.mask || rdata !== e.data) begin
        n_err++; $display("[TB] FAIL simul_drain%0d: observed %b/%h, required %b/%h", i, rvalid, rdata, e.mask, e.data); end
    end
    resp_valid = 1'b1;
    resp_data  = {32'hDEAD, 32'hDEAD, 32'hDEAD};
    #1;
    n_cmp++; if (resp_ready !== 1'b0) begin n_err++; $display("[TB] FAIL empty_ready: observed %b, required 0", resp_ready); end
    @(negedge clk);
    resp_valid = 1'b0;
    n_cmp++; if (rvalid !== 8'h00 || outstanding !== 3'd0 || rdata !== exp_rdata) begin
      n_err++; $display("[TB] FAIL empty_nochange: observed rvalid=%b occ=%0d, required rvalid=0 occ=0", rvalid, outstanding); end
    for (int i = 0; i < 10; i++) begin
      g = 8'($urandom_range(1, 255));
      push_grant(g);
      send_beat({$urandom, $urandom, $urandom});
      e = sb.pop_front();
      n_cmp++; if (rvalid !== e.mask || rdata !== e.data) begin
        n_err++; $display("[TB] FAIL wrap%0d: observed %b/%h, required %b/%h", i, rvalid, rdata, e.mask, e.data); end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    @(negedge clk);
    push_grant(8'h07);
    push_grant(8'h21);
    push_grant(8'hF1);
    push_grant(8'h48);
    rready = 8'h00;
    send_beat({32'd9, 32'd8, 32'd7});
    n_cmp++; if (outstanding !== 3'd3 || rvalid !== 8'h07) begin
      n_err++; $display("[TB] FAIL prereset: observed occ=%0d rvalid=%b, required occ=3 rvalid=07", outstanding, rvalid); end
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    rready = 8'hFF;
    model_reset();
    n_cmp++; if ({outstanding, rvalid, overflow, popcnt_err, grant_ready} !== {3'd0, 8'h00, 3'b001} || rdata !== '0) begin
      n_err++; $display("[TB] FAIL midreset: observed occ=%0d rvalid=%b ovf=%b perr=%b gr=%b, required 0/0/0/0/1",
                        outstanding, rvalid, overflow, popcnt_err, grant_ready); end
    push_grant(8'h42);
    send_beat({32'd0, 32'h4242, 32'h0202});
    e = sb.pop_front();
    n_cmp++; if (rvalid !== e.mask || rdata !== e.data) begin
      n_err++; $display("[TB] FAIL postreset: observed %b/%h, required %b/%h", rvalid, rdata, e.mask, e.data); end
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b1;
    grant      = '0;
    resp_valid = 1'b0;
    resp_data  = '0;
    rready     = 8'hFF;
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic_route();
    test_overflow();
    test_popcount();
    test_back_to_back();
    test_simul_and_wrap();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
